// File: rtl/karatsuba_result_serializer_if.sv
// Stream bundle for the Karatsuba result serializer: wide product in, W-bit beats out.
// M_tkeep exists only when SER_TKEEP_EN is defined.
interface karatsuba_result_serializer_if #(
    parameter int m = 328,
    parameter int W = 32
) ();
    logic             S_tvalid;
    logic             S_tready;
    logic [2*m-1:0]   S_tdata;
    logic             M_tvalid;
    logic             M_tready;
    logic [W-1:0]     M_tdata;
    logic             M_tlast;
`ifdef SER_TKEEP_EN
    logic [W/8-1:0]   M_tkeep;
`endif

    // master: the serializer itself (sinks products, sources beats)
    modport master (
        input  S_tvalid, S_tdata, M_tready,
        output S_tready, M_tvalid, M_tdata, M_tlast
`ifdef SER_TKEEP_EN
        , output M_tkeep
`endif
    );

    // slave: the surrounding environment (product source and beat sink)
    modport slave (
        output S_tvalid, S_tdata, M_tready,
        input  S_tready, M_tvalid, M_tdata, M_tlast
`ifdef SER_TKEEP_EN
        , input M_tkeep
`endif
    );
endinterface

// File: rtl/karatsuba_result_serializer.sv
// Splits each 2*m-bit product into ceil(2*m/W) W-bit beats, LS word first, TLAST on the last.
// Optional macro SER_TKEEP_EN adds M_tkeep byte enables.
module karatsuba_result_serializer #(
    parameter int m = 328,
    parameter int W = 32
) (
    input  logic                          clk,
    input  logic                          aresetn,
    karatsuba_result_serializer_if.master bus
);
    localparam int PW    = 2 * m;
    localparam int BEATS = (PW + W - 1) / W;
    localparam int BW    = BEATS * W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          r_state;
    state_t          w_nxt_state;
    logic [BW-1:0]   r_buf;
    logic [BW-1:0]   w_nxt_buf;
    logic [BW-1:0]   w_load;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_nxt_cnt;
    logic            w_last;
    logic            w_s_tready;

    assign w_last = (r_cnt == LAST_CNT);

    // Product zero-extended so padding bits of the final beat read as 0.
    always_comb begin
        w_load           = '0;
        w_load[PW-1:0]   = bus.S_tdata;
    end

    // Only comb in->out path: a new product is taken on the final-beat handshake.
    always_comb begin
        w_s_tready = 1'b0;
        if (aresetn) begin
            w_s_tready = (r_state == IDLE) || (w_last && bus.M_tready);
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_buf   = r_buf;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.S_tvalid) begin
                    w_nxt_state = SEND;
                    w_nxt_buf   = w_load;
                    w_nxt_cnt   = '0;
                end
            end
            SEND: begin
                if (bus.M_tready) begin
                    if (!w_last) begin
                        w_nxt_buf = r_buf >> W;
                        w_nxt_cnt = r_cnt + CW'(1);
                    end else if (bus.S_tvalid) begin
                        w_nxt_buf = w_load;
                        w_nxt_cnt = '0;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_buf   <= w_nxt_buf;
            r_cnt   <= w_nxt_cnt;
        end
    end

    assign bus.S_tready = w_s_tready;
    assign bus.M_tvalid = (r_state == SEND);
    assign bus.M_tdata  = r_buf[W-1:0];
    assign bus.M_tlast  = (r_state == SEND) && w_last;

`ifdef SER_TKEEP_EN
    localparam int KB         = W / 8;
    localparam int LAST_BYTES = (PW - (BEATS - 1) * W + 7) / 8;
    localparam logic [KB-1:0] KEEP_ALL  = {KB{1'b1}};
    localparam logic [KB-1:0] KEEP_LAST = KEEP_ALL >> (KB - LAST_BYTES);

    assign bus.M_tkeep = (r_state != SEND) ? '0 : (w_last ? KEEP_LAST : KEEP_ALL);
`else
    // No byte enables: consumers take every byte, padding included.
`endif

endmodule

// File: doc/karatsuba_result_serializer.md
Name: karatsuba_result_serializer

Overview:
- Downstream stage of the Karatsuba multiplier's AXI-Stream output.
- Accepts one 2*m-bit product per handshake and emits it as a sequence of W-bit AXI-Stream beats, least-significant word first, with TLAST on the final beat.
- Narrows the wide product bus to the DMA/interconnect width.
- Provides the TREADY backpressure that the multiplier stage itself lacks.

Parameters:
- m, 328, multiplier operand width; input product width is 2*m.
- W, 32, output beat width in bits; must be a multiple of 8.
- BEATS, derived = ceil(2*m/W), beats per product (21 for the defaults); not user-overridable.

Ports:
- clk  input  1  single clock for all interfaces.
- aresetn  input  1  asynchronous, active-low reset.
- S_tvalid  input  1  product valid.
- S_tready  output  1  block can accept a product.
- S_tdata  input  2*m  product Z.
- M_tvalid  output  1  output beat valid.
- M_tready  input  1  downstream accepts beat.
- M_tdata  output  W  output beat.
- M_tlast  output  1  final beat of the product.
- M_tkeep  output  W/8  byte enables; present only with SER_TKEEP_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset aresetn is asynchronous, active-low.
- Reset values: state=IDLE, beat counter=0, data buffer=0, M_tvalid=0, M_tlast=0, M_tdata=0. S_tready=0 while aresetn is low.
- Reset mid-frame: the partial frame is discarded, with no TLAST emitted. M_tvalid drops asynchronously.
- States: IDLE and SEND.
- IDLE:
  - S_tready=1.
  - On S_tvalid&S_tready: load buffer = S_tdata zero-extended to BEATS*W bits, set count=0, M_tvalid=1 next cycle, go to SEND.
  - Latency from input handshake to first output beat valid: 1 cycle.
- SEND:
  - M_tdata = buffer[W-1:0].
  - M_tlast = (count==BEATS-1).
  - On M_tvalid&M_tready with a non-final beat: shift buffer right by W, count++.
- Final-beat handshake:
  - If S_tvalid=1 in the same cycle: accept the new product (S_tready=1 combinationally in this case only), reload the buffer, count=0, stay in SEND, M_tvalid stays 1. This gives no bubble between frames.
  - Otherwise go to IDLE with M_tvalid=0.
- S_tready in SEND = (count==BEATS-1) & M_tready. This is the only combinational input-to-output path.
- Stall: while M_tvalid=1 and M_tready=0, M_tdata, M_tlast and M_tkeep hold stable. M_tvalid never deasserts before its handshake.
- Padding: bits above 2*m in the last beat are 0.
- BEATS==1 (2*m<=W): every beat carries M_tlast=1. The IDLE/SEND behaviour is otherwise unchanged.
- Counter width: max(1, clog2(BEATS)). The counter never exceeds BEATS-1.
- S_tvalid is ignored in SEND except on the final-beat handshake. Upstream must hold S_tdata while S_tvalid&!S_tready.

Optional Feature:
- Macro: SER_TKEEP_EN.
- Defined: port M_tkeep exists.
  - M_tkeep is all-ones on non-final beats.
  - On the final beat it has the low ceil((2*m - (BEATS-1)*W)/8) bits set, e.g. 4'b0011 for the defaults (82 bytes).
  - Reset value 0.
- Undefined: port M_tkeep and its logic are absent. Consumers treat every byte as valid, padding included.

Test Plan:
- S_tdata=656'h1, M_tready=1 -> 21 beats: beat0=32'h00000001, beats1..20=0, M_tlast only on beat 20, first M_tvalid 1 cycle after accept.
- S_tdata=all ones -> beats0..19=32'hFFFFFFFF, beat20=32'h0000FFFF. With SER_TKEEP_EN: beats0..19 tkeep=4'hF, beat20 tkeep=4'h3.
- Product 656'h...0403_0201 with M_tready toggling 1,0,1,0 -> 21 beats over about 42 cycles; M_tdata/M_tlast unchanged during each stall; beat0=32'h04030201.
- Two products back-to-back, S_tvalid held high, M_tready=1 -> 42 consecutive valid beats with no bubble. The second product is accepted in the same cycle as the first product's beat-20 handshake. S_tready is low during beats 0..19.
- aresetn pulsed low at beat 7 -> M_tvalid=0 at once and S_tready=0 during reset. The next product restarts at beat 0 with correct data.
- m=8, W=32, S_tdata=16'hBEEF -> single beat 32'h0000BEEF with M_tlast=1. With SER_TKEEP_EN, tkeep=4'b0011.
